// File: rtl/i2c_read_master_if.sv
// Host-side bundle of the I2C read master: transaction handshake, open-drain line
// enables and the captured position record.
interface i2c_read_master_if;
    logic       start;
    logic       sda_in;
    logic       scl_oe;
    logic       sda_oe;
    logic       busy;
    logic       done;
    logic       nack_err;
    logic [7:0] x_pos;
    logic [7:0] y_pos;
    logic [7:0] status;

    modport master (
        input  start, sda_in,
        output scl_oe, sda_oe, busy, done, nack_err, x_pos, y_pos, status
    );

    modport slave (
        output start, sda_in,
        input  scl_oe, sda_oe, busy, done, nack_err, x_pos, y_pos, status
    );
endinterface

// File: rtl/i2c_read_master.sv
// I2C master that reads a 3-byte position record (x, y, status) from a fixed target
// address and presents it atomically once the whole read has succeeded.
module i2c_read_master #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h64,
    parameter int unsigned CLK_DIV    = 16
) (
    input logic                clk,
    input logic                rst,
    i2c_read_master_if.master  bus
);
    localparam int unsigned     CntW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax   = CntW'(CLK_DIV - 1);
    localparam logic [7:0]      AddrByte = {SLAVE_ADDR, 1'b1};

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StStart   = 3'd1;
    localparam logic [2:0] StAddr    = 3'd2;
    localparam logic [2:0] StAddrAck = 3'd3;
    localparam logic [2:0] StRdByte  = 3'd4;
    localparam logic [2:0] StMack    = 3'd5;
    localparam logic [2:0] StStop    = 3'd6;

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      qtr_q, qtr_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            ack_q, ack_d;
    logic [7:0]      sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    logic [7:0]      x_q, x_d, y_q, y_d, st_q, st_d;
    logic            busy_q, busy_d, done_q, done_d, nack_q, nack_d;

    logic q_end, sample, slot_end;
    assign q_end    = (cnt_q == CntMax);
    assign sample   = q_end && (qtr_q == 2'd2);
    assign slot_end = q_end && (qtr_q == 2'd3);

    always_comb begin
        state_d    = state_q;
        cnt_d      = q_end ? '0 : cnt_q + CntW'(1);
        qtr_d      = q_end ? qtr_q + 2'd1 : qtr_q;
        bit_d      = bit_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        ack_d      = ack_q;
        sh0_d      = sh0_q;
        sh1_d      = sh1_q;
        sh2_d      = sh2_q;
        x_d        = x_q;
        y_d        = y_q;
        st_d       = st_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        nack_d     = nack_q;

        case (state_q)
            StIdle: begin
                // A start landing on the done cycle is dropped, not queued.
                if (bus.start && !done_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                    qtr_d   = 2'd0;
                    nack_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StStart: begin
                if (q_end && qtr_q == 2'd1) begin
                    state_d = StAddr;
                    qtr_d   = 2'd0;
                    bit_d   = 3'd0;
                end
            end
            StAddr: begin
                if (slot_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = StAddrAck;
                end
            end
            StAddrAck: begin
                if (sample) ack_d = bus.sda_in;
                if (slot_end) begin
                    if (!ack_q) begin
                        state_d    = StRdByte;
                        byte_idx_d = 2'd0;
                        bit_d      = 3'd0;
                    end else begin
                        state_d = StStop;
                        nack_d  = 1'b1;
                    end
                end
            end
            StRdByte: begin
                if (sample) shift_d = {shift_q[6:0], bus.sda_in};
                if (slot_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StMack;
                        case (byte_idx_q)
                            2'd0:    sh0_d = shift_q;
                            2'd1:    sh1_d = shift_q;
                            default: sh2_d = shift_q;
                        endcase
                    end
                end
            end
            StMack: begin
                if (slot_end) begin
                    if (!byte_idx_q[1]) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = StRdByte;
                    end else begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (slot_end) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    if (!nack_q) begin
                        x_d  = sh0_q;
                        y_d  = sh1_q;
                        st_d = sh2_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            qtr_q      <= 2'd0;
            bit_q      <= 3'd0;
            byte_idx_q <= 2'd0;
            shift_q    <= 8'h00;
            ack_q      <= 1'b0;
            sh0_q      <= 8'h00;
            sh1_q      <= 8'h00;
            sh2_q      <= 8'h00;
            x_q        <= 8'h00;
            y_q        <= 8'h00;
            st_q       <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            ack_q      <= ack_d;
            sh0_q      <= sh0_d;
            sh1_q      <= sh1_d;
            sh2_q      <= sh2_d;
            x_q        <= x_d;
            y_q        <= y_d;
            st_q       <= st_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            nack_q     <= nack_d;
        end
    end

    // Line enables decode straight from state so reset releases the bus at once.
    logic scl_oe_c, sda_oe_c;
    always_comb begin
        scl_oe_c = 1'b0;
        sda_oe_c = 1'b0;
        case (state_q)
            StStart: begin
                scl_oe_c = (qtr_q == 2'd1);
                sda_oe_c = 1'b1;
            end
            StAddr: begin
                scl_oe_c = ~qtr_q[1];
                sda_oe_c = ~AddrByte[3'd7 - bit_q];
            end
            StAddrAck, StRdByte: scl_oe_c = ~qtr_q[1];
            StMack: begin
                scl_oe_c = ~qtr_q[1];
                sda_oe_c = ~byte_idx_q[1];
            end
            StStop: begin
                scl_oe_c = (qtr_q == 2'd0);
                sda_oe_c = ~qtr_q[1];
            end
            default: ;
        endcase
    end

    assign bus.scl_oe   = scl_oe_c;
    assign bus.sda_oe   = sda_oe_c;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.nack_err = nack_q;
    assign bus.x_pos    = x_q;
    assign bus.y_pos    = y_q;
    assign bus.status   = st_q;
endmodule

// File: tb/tb_i2c_read_master.sv
// Directed bench: behavioural I2C target at 0x64 plus a START/STOP counter on the bus.
module tb_i2c_read_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_read_master_if bus ();

    i2c_read_master #(.SLAVE_ADDR(7'h64), .CLK_DIV(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Target model state
    logic       t_oe;
    logic       t_en;
    logic [7:0] tdata [3];
    logic [2:0] tph;
    logic [3:0] tcnt;
    logic [1:0] tk;
    logic [7:0] taddr;
    logic [2:0] tmack;
    logic       scl_p, sda_p;
    int         n_start = 0;
    int         n_stop  = 0;

    wire scl_l = ~bus.scl_oe;
    wire sda_l = ~(bus.sda_oe | t_oe);
    assign bus.sda_in = sda_l;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t_oe  <= 1'b0;
            tph   <= 3'd0;
            tcnt  <= 4'd0;
            tk    <= 2'd0;
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_p <= scl_l;
            sda_p <= sda_l;
            if (scl_p && scl_l && sda_p && !sda_l) begin
                n_start <= n_start + 1;
                tph     <= 3'd1;
                tcnt    <= 4'd0;
                t_oe    <= 1'b0;
            end else if (scl_p && scl_l && !sda_p && sda_l) begin
                n_stop <= n_stop + 1;
                tph    <= 3'd0;
                t_oe   <= 1'b0;
            end else if (!scl_p && scl_l) begin
                if (tph == 3'd1) begin
                    taddr <= {taddr[6:0], sda_l};
                    tcnt  <= tcnt + 4'd1;
                end
                if (tph == 3'd4) tmack[tk] <= sda_l;
            end else if (scl_p && !scl_l) begin
                case (tph)
                    3'd1: if (tcnt == 4'd8) begin
                        if (t_en && taddr == {7'h64, 1'b1}) begin
                            t_oe <= 1'b1;
                            tph  <= 3'd2;
                        end else begin
                            tph <= 3'd0;
                        end
                    end
                    3'd2: begin
                        tph  <= 3'd3;
                        tk   <= 2'd0;
                        t_oe <= ~tdata[0][7];
                        tcnt <= 4'd1;
                    end
                    3'd3: begin
                        if (tcnt < 4'd8) begin
                            t_oe <= ~tdata[tk][3'd7 - tcnt[2:0]];
                            tcnt <= tcnt + 4'd1;
                        end else begin
                            t_oe <= 1'b0;
                            tph  <= 3'd4;
                        end
                    end
                    3'd4: begin
                        if (!tmack[tk] && tk < 2'd2) begin
                            tk   <= tk + 2'd1;
                            tph  <= 3'd3;
                            t_oe <= ~tdata[tk + 2'd1][7];
                            tcnt <= 4'd1;
                        end else begin
                            tph  <= 3'd0;
                            t_oe <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic kick();
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n, output bit hit);
        n   = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            @(posedge clk); #1;
            n++;
            if (bus.done) hit = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.scl_oe, bus.sda_oe, bus.busy, bus.done, bus.nack_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {bus.scl_oe, bus.sda_oe, bus.busy, bus.done, bus.nack_err});
        end
        checks++;
        if ({bus.x_pos, bus.y_pos, bus.status} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 000000", {bus.x_pos, bus.y_pos, bus.status});
        end
        rst = 1'b0;
    endtask

    task automatic test_read();
        int n; bit hit; int s0, p0;
        t_en = 1'b1;
        tdata[0] = 8'h12; tdata[1] = 8'h34; tdata[2] = 8'h56;
        s0 = n_start; p0 = n_stop;
        kick();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL read_busy: got %b want 1", bus.busy);
        end
        wait_done(3000, n, hit);
        checks++;
        if (!hit || n != 2400) begin
            errors++; $display("FAIL read_latency: got hit=%0d n=%0d want n=2400", hit, n);
        end
        checks++;
        if ({bus.x_pos, bus.y_pos, bus.status} !== 24'h123456) begin
            errors++;
            $display("FAIL read_data: got %h want 123456", {bus.x_pos, bus.y_pos, bus.status});
        end
        checks++;
        if (bus.nack_err !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL read_flags: got nack=%b busy=%b want 0 0", bus.nack_err, bus.busy);
        end
        checks++;
        if (taddr !== 8'hC9) begin
            errors++; $display("FAIL read_addr_byte: got %h want c9", taddr);
        end
        checks++;
        if (tmack !== 3'b100) begin
            errors++; $display("FAIL read_master_acks: got %b want 100", tmack);
        end
        checks++;
        if (n_start - s0 != 1 || n_stop - p0 != 1) begin
            errors++;
            $display("FAIL read_sda_while_scl_high: got starts=%0d stops=%0d want 1 1",
                     n_start - s0, n_stop - p0);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL read_done_pulse: got %b want 0", bus.done);
        end
    endtask

    task automatic test_nack();
        int n; bit hit;
        t_en = 1'b0;
        kick();
        wait_done(1000, n, hit);
        checks++;
        if (!hit || n != 672) begin
            errors++; $display("FAIL nack_latency: got hit=%0d n=%0d want n=672", hit, n);
        end
        checks++;
        if (bus.nack_err !== 1'b1) begin
            errors++; $display("FAIL nack_flag: got %b want 1", bus.nack_err);
        end
        checks++;
        if ({bus.x_pos, bus.y_pos, bus.status} !== 24'h123456) begin
            errors++;
            $display("FAIL nack_keep: got %h want 123456", {bus.x_pos, bus.y_pos, bus.status});
        end
        checks++;
        if ({bus.scl_oe, bus.sda_oe, bus.busy} !== 3'b000) begin
            errors++;
            $display("FAIL nack_released: got %b want 000", {bus.scl_oe, bus.sda_oe, bus.busy});
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.nack_err !== 1'b1) begin
            errors++; $display("FAIL nack_held: got %b want 1", bus.nack_err);
        end
    endtask

    task automatic test_back_to_back();
        int n; bit hit;
        t_en = 1'b1;
        tdata[0] = 8'h12; tdata[1] = 8'h34; tdata[2] = 8'h56;
        kick();
        checks++;
        if (bus.nack_err !== 1'b0) begin
            errors++; $display("FAIL b2b_nack_clear: got %b want 0", bus.nack_err);
        end
        repeat (99) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(3000, n, hit);
        checks++;
        if (!hit || n != 2300) begin
            errors++; $display("FAIL busy_start_ignored: got hit=%0d n=%0d want n=2300", hit, n);
        end
        tdata[0] = 8'hFF; tdata[1] = 8'h00; tdata[2] = 8'hA5;
        bus.start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL start_on_done_ignored: got busy=%b want 0", bus.busy);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL start_after_done: got busy=%b want 1", bus.busy);
        end
        wait_done(3000, n, hit);
        checks++;
        if (!hit || n != 2400) begin
            errors++; $display("FAIL b2b_latency: got hit=%0d n=%0d want n=2400", hit, n);
        end
        checks++;
        if ({bus.x_pos, bus.y_pos, bus.status} !== 24'hFF00A5) begin
            errors++;
            $display("FAIL b2b_data: got %h want ff00a5", {bus.x_pos, bus.y_pos, bus.status});
        end
    endtask

    task automatic test_reset_mid();
        int n; bit hit; bit seen;
        tdata[0] = 8'h12; tdata[1] = 8'h34; tdata[2] = 8'h56;
        kick();
        repeat (1299) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.scl_oe, bus.sda_oe, bus.busy, bus.done} !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid_ctrl: got %b want 0000",
                     {bus.scl_oe, bus.sda_oe, bus.busy, bus.done});
        end
        checks++;
        if ({bus.x_pos, bus.y_pos, bus.status} !== 24'h0) begin
            errors++;
            $display("FAIL rst_mid_data: got %h want 000000", {bus.x_pos, bus.y_pos, bus.status});
        end
        seen = 1'b0;
        repeat (2) begin @(posedge clk); #1; if (bus.done) seen = 1'b1; end
        rst = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (bus.done) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL rst_mid_no_done: got %b want 0", seen);
        end
        kick();
        wait_done(3000, n, hit);
        checks++;
        if (!hit || n != 2400) begin
            errors++; $display("FAIL rst_recover_latency: got hit=%0d n=%0d want n=2400", hit, n);
        end
        checks++;
        if ({bus.x_pos, bus.y_pos, bus.status} !== 24'h123456) begin
            errors++;
            $display("FAIL rst_recover_data: got %h want 123456",
                     {bus.x_pos, bus.y_pos, bus.status});
        end
    endtask

    initial begin
        bus.start = 1'b0;
        t_en = 1'b1;
        tdata[0] = 8'h00; tdata[1] = 8'h00; tdata[2] = 8'h00;
        test_reset();
        test_read();
        test_nack();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
